// File: rtl/vga_pkg.sv
// Shared VGA timing types, the stock 640x480 mode and sizing helpers.
package vga_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } vga_timing_t;

    typedef struct packed {
        vga_timing_t h;
        vga_timing_t v;
    } vga_mode_t;

    localparam vga_mode_t VGA_640x480 = '{
        h: '{active: 640, fp: 16, sync: 96, bp: 48},
        v: '{active: 480, fp: 10, sync: 2,  bp: 33}
    };

    function automatic int unsigned seg_total(vga_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int unsigned clog2_min1(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wraps over active/fp/sync/bp and flags the active and sync windows.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter vga_timing_t SEG   = VGA_640x480.h,
    localparam int unsigned TOTAL = seg_total(SEG),
    localparam int unsigned W     = clog2_min1(TOTAL)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_adv,
    output logic [W-1:0] o_cnt,
    output logic         o_active,
    output logic         o_sync,
    output logic         o_wrap
);

    logic [W-1:0] r_cnt;
    logic         w_last;

    assign w_last = (r_cnt == W'(TOTAL - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_adv)
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end

    assign o_cnt    = r_cnt;
    assign o_active = (r_cnt < W'(SEG.active));
    assign o_sync   = (r_cnt >= W'(SEG.active + SEG.fp)) &&
                      (r_cnt <  W'(SEG.active + SEG.fp + SEG.sync));
    assign o_wrap   = i_adv & w_last;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-tick divider and delay pipeline.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 2,
    parameter int PIPE_DLY = 0,
    localparam int unsigned X_W = clog2_min1(H_ACTIVE),
    localparam int unsigned Y_W = clog2_min1(V_ACTIVE)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_en,
    output logic           o_pix_ce,
    output logic           o_h_sync,
    output logic           o_v_sync,
    output logic           o_blank_n,
    output logic [X_W-1:0] o_posx,
    output logic [Y_W-1:0] o_posy,
    output logic           o_line_start,
    output logic           o_frame_start
);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        CLK_DIV < 1 || PIPE_DLY < 0) begin : g_bad_param
        $error("vga_timing_gen: illegal timing parameters");
    end

    localparam vga_timing_t H_SEG = '{H_ACTIVE, H_FP, H_SYNC, H_BP};
    localparam vga_timing_t V_SEG = '{V_ACTIVE, V_FP, V_SYNC, V_BP};
    localparam int unsigned HW    = clog2_min1(seg_total(H_SEG));
    localparam int unsigned VW    = clog2_min1(seg_total(V_SEG));
    localparam int unsigned DIV_W = clog2_min1(CLK_DIV);

    typedef struct packed {
        logic           hs;
        logic           vs;
        logic           bn;
        logic           ls;
        logic           fs;
        logic [X_W-1:0] px;
        logic [Y_W-1:0] py;
    } stage_t;

    localparam stage_t STG_RST = '{hs: ~HS_POL, vs: ~VS_POL, bn: 1'b0, ls: 1'b0,
                                   fs: 1'b0, px: '0, py: '0};

    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    logic [HW-1:0]    w_hcnt;
    logic [VW-1:0]    w_vcnt;
    logic             w_hact, w_vact, w_hsync, w_vsync, w_hwrap, w_vwrap, w_act;
    logic             w_unused_vwrap;
    stage_t           w_dec;
    stage_t           r_pipe [PIPE_DLY:0];

    assign w_tick   = i_en & (r_div == DIV_W'(CLK_DIV - 1));
    assign o_pix_ce = w_tick & ~i_rst;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_div <= '0;
        else if (!i_en || w_tick)
            r_div <= '0;
        else
            r_div <= r_div + 1'b1;
    end

    vga_axis_counter #(.SEG(H_SEG)) u_hcnt (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(~i_en), .i_adv(w_tick),
        .o_cnt(w_hcnt), .o_active(w_hact), .o_sync(w_hsync), .o_wrap(w_hwrap)
    );

    vga_axis_counter #(.SEG(V_SEG)) u_vcnt (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(~i_en), .i_adv(w_hwrap),
        .o_cnt(w_vcnt), .o_active(w_vact), .o_sync(w_vsync), .o_wrap(w_vwrap)
    );

    // Frame wrap needs no action: the V counter already returns to 0 on its own.
    assign w_unused_vwrap = w_vwrap;
    assign w_act          = w_hact & w_vact;

    always_comb begin
        w_dec    = STG_RST;
        w_dec.hs = w_hsync ? HS_POL : ~HS_POL;
        w_dec.vs = w_vsync ? VS_POL : ~VS_POL;
        w_dec.bn = w_act;
        w_dec.px = w_act ? X_W'(w_hcnt) : '0;
        w_dec.py = w_act ? Y_W'(w_vcnt) : '0;
        w_dec.ls = w_act && (w_hcnt == '0);
        w_dec.fs = w_act && (w_hcnt == '0) && (w_vcnt == '0);
    end

    // Dropping en flushes every stage, so a restart never shows a truncated sync.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i <= PIPE_DLY; i++) r_pipe[i] <= STG_RST;
        end else if (!i_en) begin
            for (int i = 0; i <= PIPE_DLY; i++) r_pipe[i] <= STG_RST;
        end else if (w_tick) begin
            r_pipe[0] <= w_dec;
            for (int i = 1; i <= PIPE_DLY; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_h_sync      = r_pipe[PIPE_DLY].hs;
    assign o_v_sync      = r_pipe[PIPE_DLY].vs;
    assign o_blank_n     = r_pipe[PIPE_DLY].bn;
    assign o_posx        = r_pipe[PIPE_DLY].px;
    assign o_posy        = r_pipe[PIPE_DLY].py;
    assign o_line_start  = r_pipe[PIPE_DLY].ls;
    assign o_frame_start = r_pipe[PIPE_DLY].fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Two small-raster instances checked each cycle against an arithmetic raster model.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit hpol, vpol;
        int div, dly;
    } cfg_t;

    typedef struct {
        bit ce, hs, vs, bn, ls, fs;
        int px, py;
    } out_t;

    localparam cfg_t CA = '{ha:4, hf:1, hs:1, hb:1, va:3, vf:1, vs:1, vb:1,
                            hpol:1'b0, vpol:1'b0, div:1, dly:0};
    localparam cfg_t CB = '{ha:5, hf:2, hs:3, hb:2, va:4, vf:1, vs:2, vb:1,
                            hpol:1'b1, vpol:1'b0, div:3, dly:2};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    int   t   = 0;        // clk edges seen with en=1 since last reset/disable
    int   nvec = 0;
    int   nbad = 0;

    logic       a_ce, a_hs, a_vs, a_bn, a_ls, a_fs;
    logic [1:0] a_px, a_py;
    logic       b_ce, b_hs, b_vs, b_bn, b_ls, b_fs;
    logic [2:0] b_px;
    logic [1:0] b_py;

    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(1), .PIPE_DLY(0)) u_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .o_pix_ce(a_ce), .o_h_sync(a_hs),
        .o_v_sync(a_vs), .o_blank_n(a_bn), .o_posx(a_px), .o_posy(a_py),
        .o_line_start(a_ls), .o_frame_start(a_fs)
    );

    vga_timing_gen #(.H_ACTIVE(5), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(3), .PIPE_DLY(2)) u_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .o_pix_ce(b_ce), .o_h_sync(b_hs),
        .o_v_sync(b_vs), .o_blank_n(b_bn), .o_posx(b_px), .o_posy(b_py),
        .o_line_start(b_ls), .o_frame_start(b_fs)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst)     t <= 0;
        else if (en) t <= t + 1;
        else         t <= 0;
    end

    // Pixel p = (ticks so far) - 1 - delay; negative means the pipe is still empty.
    function automatic out_t model(cfg_t c, int tt, bit e, bit r);
        out_t o;
        int ht, vt, k, p, h, v, hs0, vs0;
        bit act;
        o = '{ce:1'b0, hs:~c.hpol, vs:~c.vpol, bn:1'b0, ls:1'b0, fs:1'b0, px:0, py:0};
        if (r) return o;
        ht  = c.ha + c.hf + c.hs + c.hb;
        vt  = c.va + c.vf + c.vs + c.vb;
        o.ce = e && ((tt % c.div) == c.div - 1);
        k   = tt / c.div;
        p   = k - 1 - c.dly;
        if (p < 0) return o;
        h   = p % ht;
        v   = (p / ht) % vt;
        hs0 = c.ha + c.hf;
        vs0 = c.va + c.vf;
        act = (h < c.ha) && (v < c.va);
        o.bn = act;
        o.px = act ? h : 0;
        o.py = act ? v : 0;
        o.ls = act && (h == 0);
        o.fs = act && (h == 0) && (v == 0);
        o.hs = (h >= hs0 && h < hs0 + c.hs) ? c.hpol : ~c.hpol;
        o.vs = (v >= vs0 && v < vs0 + c.vs) ? c.vpol : ~c.vpol;
        return o;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s t=%0d got=%0h exp=%0h @%0t", nm, t, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(string tag, cfg_t c, logic ce, logic hs, logic vs, logic bn,
                           logic ls, logic fs, logic [31:0] px, logic [31:0] py);
        out_t o;
        o = model(c, t, en, rst);
        chk({tag, ".pix_ce"},      32'(ce), 32'(o.ce));
        chk({tag, ".h_sync"},      32'(hs), 32'(o.hs));
        chk({tag, ".v_sync"},      32'(vs), 32'(o.vs));
        chk({tag, ".blank_n"},     32'(bn), 32'(o.bn));
        chk({tag, ".line_start"},  32'(ls), 32'(o.ls));
        chk({tag, ".frame_start"}, 32'(fs), 32'(o.fs));
        chk({tag, ".posx"},        px, 32'(o.px));
        chk({tag, ".posy"},        py, 32'(o.py));
    endtask

    task automatic check_all();
        cmp_dut("A", CA, a_ce, a_hs, a_vs, a_bn, a_ls, a_fs, 32'(a_px), 32'(a_py));
        cmp_dut("B", CB, b_ce, b_hs, b_vs, b_bn, b_ls, b_fs, 32'(b_px), 32'(b_py));
    endtask

    int low_left = 0;

    initial begin
        // Reset values, held across edges
        repeat (2) @(negedge clk);
        chk("rst.A.h_sync", 32'(a_hs), 32'd1);
        chk("rst.B.h_sync", 32'(b_hs), 32'd0);
        chk("rst.B.v_sync", 32'(b_vs), 32'd1);
        chk("rst.A.blank_n", 32'(a_bn), 32'd0);
        chk("rst.A.pix_ce", 32'(a_ce), 32'd0);
        check_all();
        rst = 1'b0;
        en  = 1'b1;

        // Directed start: n = clk edges since en rose
        for (int n = 1; n <= 90; n++) begin
            @(negedge clk);
            check_all();
            case (n)
                1:  begin chk("pin.A.first_bn", 32'(a_bn), 32'd1);
                          chk("pin.A.first_fs", 32'(a_fs), 32'd1);
                          chk("pin.A.first_px", 32'(a_px), 32'd0);
                          chk("pin.B.not_yet",  32'(b_bn), 32'd0); end
                3:  chk("pin.A.ce_const", 32'(a_ce), 32'd1);
                6:  chk("pin.A.hsync_on", 32'(a_hs), 32'd0);
                7:  chk("pin.A.hsync_off", 32'(a_hs), 32'd1);
                8:  begin chk("pin.A.line1_ls", 32'(a_ls), 32'd1);
                          chk("pin.A.line1_py", 32'(a_py), 32'd1);
                          chk("pin.A.line1_fs", 32'(a_fs), 32'd0);
                          chk("pin.B.pre_first", 32'(b_bn), 32'd0); end
                9:  begin chk("pin.B.first_bn", 32'(b_bn), 32'd1);
                          chk("pin.B.first_fs", 32'(b_fs), 32'd1); end
                29: begin chk("pin.A.vsync_on", 32'(a_vs), 32'd0);
                          chk("pin.B.hs_pre",   32'(b_hs), 32'd0); end
                30: chk("pin.B.hsync_hi", 32'(b_hs), 32'd1);
                36: chk("pin.A.vsync_off", 32'(a_vs), 32'd1);
                default: ;
            endcase
        end

        // Randomised en drops and async reset pulses
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            check_all();
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
            end
            if (low_left > 0) begin
                low_left--;
                en = (low_left == 0);
            end else if ($urandom_range(0, 399) == 0) begin
                low_left = $urandom_range(1, 4);
                en = 1'b0;
            end
            #1;
            check_all();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
